// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter
// Description : Parametrised barrel shifter. It supports SLL/SRL/SRA/ROL/ROR
//               and pass-through ops, with STAGES register groups and a
//               valid/ready handshake that honours full backpressure. A
//               sideband tag travels with each operation.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [WIDTH-1:0]         i_in_data,
    input  logic [$clog2(WIDTH)-1:0] i_in_amount,
    input  logic [2:0]               i_in_op,
    input  logic [TAG_W-1:0]         i_in_tag,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [WIDTH-1:0]         o_out_data,
    output logic [TAG_W-1:0]         o_out_tag
);

    localparam int c_LOGW = $clog2(WIDTH);
    // Layers per register group; the final group may hold fewer (or none).
    localparam int c_LPS  = (c_LOGW + STAGES - 1) / STAGES;
    localparam int c_LAST = STAGES - 1;

    localparam logic [2:0] c_OP_SLL = 3'b000;
    localparam logic [2:0] c_OP_SRL = 3'b001;
    localparam logic [2:0] c_OP_SRA = 3'b010;
    localparam logic [2:0] c_OP_ROL = 3'b011;
    localparam logic [2:0] c_OP_ROR = 3'b100;

    localparam logic [WIDTH-1:0] c_ONES = '1;
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 2");
    end
    if (STAGES < 1 || STAGES > c_LOGW) begin : g_bad_stages
        $error("pipelined_barrel_shifter: STAGES must be in 1..log2(WIDTH)");
    end

    // Right-direction ops run on the left-shift datapath with the operand
    // bit-reversed on the way in and the result reversed on the way out.
    function automatic logic f_is_right(input logic [2:0] op);
        return (op == c_OP_SRL) || (op == c_OP_SRA) || (op == c_OP_ROR);
    endfunction

    function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

    // Per-stage registers
    logic [STAGES-1:0]  r_vld;
    logic [WIDTH-1:0]   r_data [STAGES];
    logic [c_LOGW-1:0]  r_amt  [STAGES];
    logic [2:0]         r_op   [STAGES];
    logic               r_sign [STAGES];
    logic [TAG_W-1:0]   r_tag  [STAGES];

    // Inputs seen by each stage (stage 0 from the ports, others from the
    // previous register)
    logic [WIDTH-1:0]   w_stg_data [STAGES];
    logic [c_LOGW-1:0]  w_stg_amt  [STAGES];
    logic [2:0]         w_stg_op   [STAGES];
    logic               w_stg_sign [STAGES];
    logic [TAG_W-1:0]   w_stg_tag  [STAGES];
    logic               w_stg_vld  [STAGES];
    logic [WIDTH-1:0]   w_shf      [STAGES];
    logic [STAGES-1:0]  w_adv;

    // Route port inputs into stage 0 and each register into the next stage
    always_comb begin
        w_stg_data[0] = f_is_right(i_in_op) ? f_rev(i_in_data) : i_in_data;
        w_stg_amt[0]  = i_in_amount;
        w_stg_op[0]   = i_in_op;
        w_stg_sign[0] = i_in_data[WIDTH-1];
        w_stg_tag[0]  = i_in_tag;
        w_stg_vld[0]  = i_in_valid;
        for (int s = 1; s < STAGES; s++) begin
            w_stg_data[s] = r_data[s-1];
            w_stg_amt[s]  = r_amt[s-1];
            w_stg_op[s]   = r_op[s-1];
            w_stg_sign[s] = r_sign[s-1];
            w_stg_tag[s]  = r_tag[s-1];
            w_stg_vld[s]  = r_vld[s-1];
        end
    end

    // Shift layers of each group: layer k shifts left by 2^k when amount[k]
    // is set; pass-through ops leave the data untouched
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            w_shf[s] = w_stg_data[s];
            for (int k = 0; k < c_LOGW; k++) begin
                if ((k / c_LPS) == s && w_stg_amt[s][k] && w_stg_op[s] <= c_OP_ROR) begin
                    if (w_stg_op[s] == c_OP_ROL || w_stg_op[s] == c_OP_ROR) begin
                        w_shf[s] = (w_shf[s] << (1 << k)) | (w_shf[s] >> (WIDTH - (1 << k)));
                    end else begin
                        w_shf[s] = (w_shf[s] << (1 << k)) |
                                   ((w_stg_op[s] == c_OP_SRA && w_stg_sign[s]) ?
                                    ~(c_ONES << (1 << k)) : c_ZERO);
                    end
                end
            end
        end
    end

    // Advance chain: a stage moves when empty or when its successor moves
    always_comb begin
        w_adv         = '0;
        w_adv[c_LAST] = !r_vld[c_LAST] || i_out_ready;
        for (int s = STAGES - 2; s >= 0; s--) begin
            w_adv[s] = !r_vld[s] || w_adv[s+1];
        end
    end

    assign o_in_ready = w_adv[0];

    // Stage registers; reset asynchronously discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_data[s] <= '0;
                r_amt[s]  <= '0;
                r_op[s]   <= '0;
                r_sign[s] <= 1'b0;
                r_tag[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (w_adv[s]) begin
                    r_vld[s]  <= w_stg_vld[s];
                    r_data[s] <= w_shf[s];
                    r_amt[s]  <= w_stg_amt[s];
                    r_op[s]   <= w_stg_op[s];
                    r_sign[s] <= w_stg_sign[s];
                    r_tag[s]  <= w_stg_tag[s];
                end
            end
        end
    end

    // Output: undo the entry reversal; data and tag read zero when idle
    always_comb begin
        o_out_valid = r_vld[c_LAST];
        o_out_data  = '0;
        o_out_tag   = '0;
        if (r_vld[c_LAST]) begin
            o_out_data = f_is_right(r_op[c_LAST]) ? f_rev(r_data[c_LAST]) : r_data[c_LAST];
            o_out_tag  = r_tag[c_LAST];
        end
    end

endmodule
`default_nettype wire

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined barrel shifter for the ALU/execute path. It generalises the fixed 32-bit, fill-bit, left-only shifter in four ways: any power-of-two width, logical/arithmetic/rotate modes in both directions, a configurable number of register stages, and a valid/ready handshake with full backpressure. Each accepted operation carries a sideband tag to the output so the issue logic can match results to requests.

Parameters:
WIDTH, 32, data width; power of two, at least 2. Elaboration error otherwise.
STAGES, 2, pipeline register stages, 1..log2(WIDTH). Elaboration error outside that range.
TAG_W, 4, width of the sideband tag passed through unchanged.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request present
in_ready  out  1  block can accept a request this cycle
in_data  in  WIDTH  operand
in_amount  in  log2(WIDTH)  shift distance, unsigned
in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through
in_tag  in  TAG_W  sideband, returned with the result
out_valid  out  1  result present
out_ready  in  1  consumer accepts the result
out_data  out  WIDTH  result
out_tag  out  TAG_W  tag of the result

Behaviour:
- Layers: log2(WIDTH) shift layers, each of distance 2^k, enabled by amount[k], processed LSB first.
- Staging: layers are grouped into STAGES groups of ceil(log2(WIDTH)/STAGES) layers; the last group may be smaller. Each group ends in a register.
- Per-stage register contents: data, remaining amount bits, op, the sign bit captured at input, tag, and a valid flag.
- Right shifts and rotates are implemented by bit-reversing at entry and exit around the left-shift datapath. The sign bit is always taken from the original in_data[WIDTH-1].
- Fill rules:
  - SLL and SRL fill with 0.
  - SRA fills with in_data[WIDTH-1].
  - ROL and ROR wrap the shifted-out bits back in.
  - Pass-through ops ignore amount and take the same latency.
- amount = 0 returns in_data unchanged for every op. Amounts are always below WIDTH, so there is no overflow case.
- Latency: exactly STAGES cycles from the accepting edge (in_valid && in_ready) to out_valid, when out_ready stays high.
- Throughput: one operation per cycle when out_ready stays high.
- Handshake:
  - Stage i advances when it is empty, or when stage i+1 advances or is empty. The final stage advances on out_ready.
  - in_ready = !valid[0] || advance[0]. It is combinational from out_ready through the chain; this path is accepted.
  - No bubbles: with out_ready low, the pipeline fills to STAGES entries, then in_ready drops.
  - out_data and out_tag hold stable while out_valid && !out_ready.
- Simultaneous accept and drain in the same cycle: both occur and no entry is lost or duplicated.
- in_valid with in_ready low: the request is not consumed; the source must hold it.
- Reset:
  - While rst_n is low, or at any time it asserts mid-operation: all valid flags clear immediately (asynchronously) and in-flight results are discarded.
  - out_valid = 0, out_data = 0, out_tag = 0.
  - in_ready = 1 from the first cycle after deassertion.
  - Datapath registers may be reset or left unreset, but out_data and out_tag must read 0 while out_valid = 0 after reset.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1, back-to-back requests:
  - SLL 0x00000001 by 31 -> 0x80000000
  - SRL 0x80000000 by 31 -> 0x00000001
  - SRA 0x80000000 by 4 -> 0xF8000000
  - ROR 0x12345678 by 8 -> 0x78123456
  - ROL 0x80000001 by 1 -> 0x00000003
  - Required: outputs arrive on consecutive cycles, each exactly 2 cycles after acceptance, tags returned in order.
- Op 101 with amount 7 on 0xDEADBEEF -> 0xDEADBEEF after 2 cycles; amount=0 with each of the five ops -> input unchanged.
- Backpressure, STAGES=2:
  - Hold out_ready=0 and offer tags 1,2,3 -> in_ready drops after 2 accepts; out_valid stays high with tag 1 and stable data.
  - Raise out_ready -> tags 1,2,3 delivered in order with no loss or duplication.
- Accept and drain in the same cycle with a full pipeline -> occupancy stays at 2 and in_ready stays 1.
- Reset mid-operation: assert rst_n=0 with 2 entries in flight -> out_valid=0 and out_data=0 immediately, without a clock edge; after release, in_ready=1 and no stale result appears.
- Sweep WIDTH=8 with STAGES=1 and 3, exhaustive over data, amount and op against a reference model -> all results match; latency equals STAGES.
